// File: rtl/maj_vote_pkg.sv
// Shared types, constants and round-robin helper for the majority-vote arbiter.
package maj_vote_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int VOTE_W     = 5;
  localparam int MAJ_THRESH = 3;
  localparam int RR_MAX     = 8;

  // First set request bit at or after ptr, scanning upward and wrapping at n_req.
  // Request bits at or above n_req must be zero.
  function automatic logic [2:0] next_rr(input logic [RR_MAX-1:0] req,
                                         input logic [2:0]        ptr,
                                         input int                n_req);
    logic [2:0] win;
    logic       found;
    int         idx;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < RR_MAX; i++) begin
      idx = (int'(ptr) + i) % n_req;
      if (i < n_req && !found && req[idx[2:0]]) begin
        win   = idx[2:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/maj5_core.sv
// Combinational 5-input majority built from an 8-to-1 mux.
// The low three votes pick how many of the top two are still needed.
module maj5_core
  import maj_vote_pkg::*;
(
  input  logic [VOTE_W-1:0] i_vote,
  output logic              o_maj
);

  logic w_a;
  logic w_b;

  assign w_a = i_vote[4];
  assign w_b = i_vote[3];

  // Mux on the low three bits: 0 ones -> 0, 1 -> a&b, 2 -> a|b, 3 -> 1
  always_comb begin
    o_maj = 1'b0;
    case (i_vote[2:0])
      3'd0:    o_maj = 1'b0;
      3'd1:    o_maj = w_a & w_b;
      3'd2:    o_maj = w_a & w_b;
      3'd3:    o_maj = w_a | w_b;
      3'd4:    o_maj = w_a & w_b;
      3'd5:    o_maj = w_a | w_b;
      3'd6:    o_maj = w_a | w_b;
      3'd7:    o_maj = 1'b1;
      default: o_maj = 1'b0;
    endcase
  end

endmodule

// File: rtl/maj_vote_arbiter.sv
// Round-robin arbiter sharing one majority core between N_REQ requesters.
// Flow: arbitrate (IDLE/RESP edge) -> EVAL (gnt high) -> RESP (rsp_valid high).
module maj_vote_arbiter
  import maj_vote_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [VOTE_W*N_REQ-1:0]   vote,
  output logic [N_REQ-1:0]          gnt,
  output logic                      busy,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      rsp_maj
);

  state_t              r_state;
  state_t              w_next;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_id;
  logic [ID_W-1:0]     r_rsp_id;
  logic [ID_W-1:0]     w_win;
  logic [VOTE_W-1:0]   r_vote;
  logic [VOTE_W-1:0]   w_win_vote;
  logic [N_REQ-1:0]    r_gnt;
  logic                r_maj;
  logic                w_arb;
  logic                w_maj;

  // Arbitration happens on any edge leaving IDLE or RESP with a pending request
  assign w_arb      = (r_state != EVAL) && (|req);
  assign w_win      = ID_W'(next_rr(8'(req), 3'(r_ptr), N_REQ));
  assign w_win_vote = vote[VOTE_W*w_win +: VOTE_W];

  maj5_core u_core (
    .i_vote (r_vote),
    .o_maj  (w_maj)
  );

  // Next-state logic for the capture/evaluate/respond sequence
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (|req) w_next = EVAL;
      EVAL:    w_next = RESP;
      RESP:    w_next = (|req) ? EVAL : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Capture winner on arbitration edges, register the result when leaving EVAL
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gnt    <= '0;
      r_ptr    <= '0;
      r_id     <= '0;
      r_vote   <= '0;
      r_rsp_id <= '0;
      r_maj    <= 1'b0;
    end else begin
      r_gnt <= '0;
      if (w_arb) begin
        r_vote <= w_win_vote;
        r_id   <= w_win;
        r_gnt  <= N_REQ'(1) << w_win;
        r_ptr  <= (w_win == ID_W'(N_REQ - 1)) ? '0 : w_win + 1'b1;
      end
      if (r_state == EVAL) begin
        r_maj    <= w_maj;
        r_rsp_id <= r_id;
      end
    end
  end

  assign gnt       = r_gnt;
  assign busy      = (r_state != IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_id    = r_rsp_id;
  assign rsp_maj   = r_maj;

endmodule

// File: tb/tb_maj_vote_arbiter.sv
// Self-checking bench for maj_vote_arbiter: vector table, directed corner
// sequences and randomized traffic against a transaction-level model.
module tb_maj_vote_arbiter;
  import maj_vote_pkg::*;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  req;
  logic [5*N-1:0] vote;
  logic [N-1:0]  gnt;
  logic          busy;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic          rsp_maj;

  logic [4:0]    core_vote;
  logic          core_maj;

  int n_chk  = 0;
  int n_pass = 0;

  maj_vote_arbiter #(.N_REQ(N), .ID_W(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .vote      (vote),
    .gnt       (gnt),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_maj   (rsp_maj)
  );

  maj5_core u_core_chk (
    .i_vote (core_vote),
    .o_maj  (core_maj)
  );

  always #5 clk = ~clk;

  // Model: a grant may only happen on an edge not directly following a grant.
  int   m_ptr;
  logic p1_v, p2_v;
  int   p1_w, p2_w;
  logic p1_maj, p2_maj;
  logic [N-1:0] e_gnt;
  logic e_busy, e_vld, e_maj;
  logic [1:0] e_id;

  function automatic int rr_pick(logic [N-1:0] r, int p);
    int best, bestd, d;
    best  = -1;
    bestd = N;
    for (int k = 0; k < N; k++) begin
      d = (k - p + N) % N;
      if (r[k] && d < bestd) begin
        best  = k;
        bestd = d;
      end
    end
    return best;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_ptr = 0;
    p1_v = 0; p2_v = 0; p1_w = 0; p2_w = 0; p1_maj = 0; p2_maj = 0;
    e_gnt = '0; e_busy = 0; e_vld = 0; e_id = '0; e_maj = 0;
  endtask

  // Predict the coming edge from current inputs, clock it, compare everything.
  task automatic tick();
    int   w;
    logic nv, nmaj;
    int   nw;
    if (!reset_n) begin
      model_reset();
    end else begin
      nv = 0; nw = 0; nmaj = 0;
      if (!p1_v && |req) begin
        w    = rr_pick(req, m_ptr);
        nv   = 1;
        nw   = w;
        nmaj = ($countones(vote[5*w +: 5]) >= MAJ_THRESH);
        m_ptr = (w + 1) % N;
      end
      p2_v = p1_v; p2_w = p1_w; p2_maj = p1_maj;
      p1_v = nv;   p1_w = nw;   p1_maj = nmaj;
      e_gnt  = p1_v ? (N'(1) << p1_w) : '0;
      e_busy = p1_v || p2_v;
      e_vld  = p2_v;
      if (p2_v) begin
        e_id  = 2'(p2_w);
        e_maj = p2_maj;
      end
    end
    @(posedge clk);
    #1;
    chk("outputs{gnt,busy,vld,id,maj}", {gnt, busy, rsp_valid, rsp_id, rsp_maj},
        {e_gnt, e_busy, e_vld, e_id, e_maj});
  endtask

  typedef struct {
    int         id;
    logic [4:0] v;
    logic       maj;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [N-1:0] seen;
    int order[5];
    int ord_n;
    int gap_ok;
    int last_g;

    tbl[0] = '{0, 5'b00111, 1'b1};
    tbl[1] = '{0, 5'b11000, 1'b0};
    tbl[2] = '{2, 5'b10101, 1'b1};
    tbl[3] = '{2, 5'b10001, 1'b0};
    tbl[4] = '{2, 5'b00000, 1'b0};
    tbl[5] = '{2, 5'b11111, 1'b1};
    tbl[6] = '{3, 5'b01110, 1'b1};
    tbl[7] = '{1, 5'b01001, 1'b0};

    reset_n = 1'b0; req = '0; vote = '0; core_vote = '0;
    model_reset();
    #1;
    chk("reset_state", {gnt, busy, rsp_valid, rsp_id, rsp_maj}, 9'd0);
    tick();
    reset_n = 1'b1;

    // Majority core on its own, all 32 vectors
    for (int v = 0; v < 32; v++) begin
      core_vote = 5'(v);
      #1;
      chk("core_maj", core_maj, ($countones(core_vote) >= MAJ_THRESH));
    end

    // Table of single-requester transactions
    for (int i = 0; i < 8; i++) begin
      req = N'(1) << tbl[i].id;
      vote[5*tbl[i].id +: 5] = tbl[i].v;
      tick();
      chk("tbl_gnt", gnt, N'(1) << tbl[i].id);
      req = '0;
      tick();
      chk("tbl_rsp", {rsp_valid, rsp_id, rsp_maj}, {1'b1, 2'(tbl[i].id), tbl[i].maj});
      tick();
      chk("tbl_idle", busy, 1'b0);
    end

    // Requester 2 sweeps every vote vector through the arbiter
    for (int v = 0; v < 32; v++) begin
      req = 4'b0100;
      vote[14:10] = 5'(v);
      tick();
      req = '0;
      tick();
      chk("sweep_maj", rsp_maj, ($countones(5'(v)) >= 3));
      tick();
    end

    // Pointer wrap: after granting 3, requests {3,0} go to 0
    req = 4'b1000;
    tick();
    req = '0;
    tick();
    req = 4'b1001;
    tick();
    chk("wrap_gnt", gnt, 4'b0001);
    req = 4'b1000;
    tick();
    tick();
    chk("wrap_then3", gnt, 4'b1000);
    req = '0;
    tick(); tick(); tick();

    // Request withdrawn during EVAL is never granted
    seen = '0;
    req = 4'b0001;
    tick(); seen |= gnt;
    req = 4'b0010;
    tick(); seen |= gnt;
    req = '0;
    tick(); seen |= gnt;
    tick(); seen |= gnt;
    chk("withdrawn_no_gnt1", seen[1], 1'b0);

    // Asynchronous reset in the middle of EVAL
    req = 4'b0001;
    vote[4:0] = 5'b11111;
    tick();
    req = '0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_outs", {gnt, busy, rsp_valid}, 6'd0);
    model_reset();
    tick();
    @(negedge clk);
    reset_n = 1'b1;
    req = 4'b0100;
    vote[14:10] = 5'b00011;
    tick();
    chk("post_rst_gnt", gnt, 4'b0100);
    req = '0;
    tick();
    chk("post_rst_rsp", {rsp_valid, rsp_id, rsp_maj}, {1'b1, 2'd2, 1'b0});
    tick();

    // Fairness from a fresh pointer: everyone requesting continuously
    reset_n = 1'b0;
    model_reset();
    tick();
    reset_n = 1'b1;
    vote = {5'b11100, 5'b00001, 5'b10110, 5'b01011};
    req = 4'b1111;
    ord_n = 0; gap_ok = 1; last_g = -10;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (gnt != '0) begin
        if (ord_n < 5) order[ord_n] = $clog2(gnt);
        if (ord_n > 0 && c - last_g != 2) gap_ok = 0;
        ord_n++;
        last_g = c;
      end
      req = 4'b1111 & ~gnt;
    end
    chk("fair_count", ord_n, 5);
    chk("fair_order", {order[0][3:0], order[1][3:0], order[2][3:0], order[3][3:0], order[4][3:0]},
        20'h01230);
    chk("fair_spacing", gap_ok, 1);
    req = '0;
    tick(); tick(); tick();

    // Randomized traffic with protocol-correct requesters
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < N; k++) begin
        if (e_gnt[k]) req[k] = 1'b0;
        else if (!req[k]) begin
          if ($urandom_range(0, 2) == 0) begin
            vote[5*k +: 5] = 5'($urandom_range(0, 31));
            req[k] = 1'b1;
          end
        end else if ($urandom_range(0, 15) == 0) req[k] = 1'b0;
      end
      tick();
    end
    req = '0;
    tick(); tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
